// File: rtl/vec_tile_pkg.sv
// vec_tile_pkg: shared FSM state type and default sizing for the vector memory loader
package vec_tile_pkg;

    typedef enum logic [1:0] {FILL, REQ, WAIT_ACK, FIRE} state_t;

    localparam int WIDTH_DEF      = 16;
    localparam int NUM_INPUTS_DEF = 8;
    localparam int TIMEOUT_DEF    = 64;

endpackage

// File: rtl/vec_lane_assembler.sv
// vec_lane_assembler: lane index, lane registers and zero-fill of unused lanes
module vec_lane_assembler
    import vec_tile_pkg::*;
#(
    parameter int width      = WIDTH_DEF,
    parameter int num_inputs = NUM_INPUTS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             acc_i,
    input  logic [width-1:0] data_i,
    input  logic             last_i,
    input  logic             clr_i,
    output logic             done_o,
    output logic             idx_zero_o,
    output logic [width-1:0] lanes_o [num_inputs:0]
);

    localparam int IW = $clog2(num_inputs + 2);

    logic [IW-1:0]    idx_q, idx_d;
    logic [width-1:0] lanes_q [num_inputs:0];
    logic [width-1:0] lanes_d [num_inputs:0];

    assign done_o     = acc_i & (last_i | (idx_q == IW'(num_inputs)));
    assign idx_zero_o = idx_q == '0;
    assign lanes_o    = lanes_q;

    // first word of a vector clears stale lanes so a short vector reads zero above its end
    always_comb begin
        idx_d = clr_i ? '0 : acc_i ? idx_q + IW'(1) : idx_q;
        for (int i = 0; i <= num_inputs; i++)
            lanes_d[i] = !acc_i ? lanes_q[i] : (idx_q == IW'(i)) ? data_i : (idx_q == '0) ? '0 : lanes_q[i];
    end

    // lane and index registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            lanes_q <= '{default: '0};
        end else begin
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: rtl/vec_mem_loader.sv
// vec_mem_loader: gathers scalar words into a lane vector, writes it to memory, optionally fires the FU
// Define VEC_LOADER_TIMEOUT_EN to enable the write_ack watchdog and err_timeout.
module vec_mem_loader
    import vec_tile_pkg::*;
#(
    parameter int width          = WIDTH_DEF,
    parameter int num_inputs     = NUM_INPUTS_DEF,
    parameter int timeout_cycles = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    input  logic             in_last,
    input  logic             auto_run,
    input  logic             write_rdy,
    output logic             write_en,
    output logic [width-1:0] w_data_out [num_inputs:0],
    input  logic             write_ack,
    output logic             on_off,
    output logic             busy,
    output logic [15:0]      vec_count,
    output logic             err_timeout
);

    state_t      state_q;
    logic        write_en_q, on_off_q;
    logic [15:0] vec_count_q;
    logic        done, idx_zero, commit, timeout;

    assign in_ready  = state_q == FILL;
    assign commit    = (state_q == WAIT_ACK) & write_ack;
    assign busy      = (state_q != FILL) | !idx_zero;
    assign write_en  = write_en_q;
    assign on_off    = on_off_q;
    assign vec_count = vec_count_q;

    vec_lane_assembler #(.width(width), .num_inputs(num_inputs)) u_lanes (
        .clk        (clk),
        .reset      (reset),
        .acc_i      (in_valid & in_ready),
        .data_i     (in_data),
        .last_i     (in_last),
        .clr_i      (commit | timeout),
        .done_o     (done),
        .idx_zero_o (idx_zero),
        .lanes_o    (w_data_out)
    );

`ifdef VEC_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(timeout_cycles + 1);

    logic [TW-1:0] wd_q;
    logic          err_q;

    assign timeout     = (state_q == WAIT_ACK) & !write_ack & (wd_q == TW'(timeout_cycles - 1));
    assign err_timeout = err_q;

    // watchdog counts WAIT_ACK cycles; the error flag is sticky until reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= ((state_q == WAIT_ACK) & !timeout) ? wd_q + TW'(1) : '0;
            err_q <= err_q | timeout;
        end
    end
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // control FSM with registered write_en, on_off and commit counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            write_en_q  <= 1'b0;
            on_off_q    <= 1'b0;
            vec_count_q <= '0;
        end else begin
            on_off_q <= 1'b0;
            case (state_q)
                FILL: if (done) state_q <= REQ;
                REQ: if (write_rdy) begin
                    state_q    <= WAIT_ACK;
                    write_en_q <= 1'b1;
                end
                WAIT_ACK: if (write_ack) begin
                    write_en_q  <= 1'b0;
                    vec_count_q <= vec_count_q + 16'd1;
                    on_off_q    <= auto_run;
                    state_q     <= auto_run ? FIRE : FILL;
                end else if (timeout) begin
                    write_en_q <= 1'b0;
                    state_q    <= FILL;
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule
